uart_rx_ctrl: RTL and testbench

Control and buffering wrapper for the UART receive engine (uart_rx).
- Sequences the engine's enable so that a disable request never truncates a frame in flight.
- Captures each received character together with its parity/framing/break flags into a show-ahead RX FIFO.
- Drives the CPU-facing read port, the watermark interrupt, the character-timeout interrupt and the sticky overrun status.
- Sits between uart_rx and the UART register block.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 82 ++++++++
 rtl/uart_rx_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: enable-FSM encodings,
// error-flag bit positions and the receive-queue entry format.
package uart_pkg;

  typedef enum logic [1:0] {
    UART_RXC_OFF  = 2'd0,
    UART_RXC_RUN  = 2'd1,
    UART_RXC_STOP = 2'd2
  } rxc_state_e;

  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_BRK = 2;
  localparam int RXQ_W   = 11;

  // Entry layout: flags in the top three bits, character in the low byte.
  function automatic logic [RXQ_W-1:0] rxq_pack(input logic brk, input logic frm,
                                                input logic par, input logic [7:0] bits);
    logic [2:0] flags;
    flags          = 3'b000;
    flags[ERR_BRK] = brk;
    flags[ERR_FRM] = frm;
    flags[ERR_PAR] = par;
    return {flags, bits};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO with flush; the head entry is visible
// combinationally and the next-state occupancy is exported for look-ahead logic.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = RXQ_W
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic [AW:0]   count_next,
  output logic          full,
  output logic          empty,
  output logic          push_ok,
  output logic          pop_ok
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  assign empty = (count_r == {(AW+1){1'b0}});
  assign full  = (count_r == (AW+1)'(DEPTH));
  assign count = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // A push into a full queue only fits when a pop frees a slot in the same cycle.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  always_comb begin
    count_next = count_r;
    if (flush) begin
      count_next = {(AW+1){1'b0}};
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_r + (AW+1)'(1);
        2'b01:   count_next = count_r - (AW+1)'(1);
        default: count_next = count_r;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (push_ok) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: enable sequencing, RX queue capture, CPU read port,
// watermark / character-timeout interrupts and sticky overrun.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cfg_en,
  input  logic [AW:0]   cfg_wm,
  input  logic [15:0]   cfg_tmo,
  input  logic          flush,
  input  logic          clr_ovr,
  output logic          rx_en,
  input  logic          rx_valid,
  input  logic [7:0]    rx_bits,
  input  logic          rx_perr,
  input  logic          rx_ferr,
  input  logic          rx_berr,
  input  logic          rx_idle,
  input  logic          rd_pop,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic [2:0]    rd_err,
  output logic [AW:0]   count,
  output logic          ovr,
  output logic          irq_wm,
  output logic          irq_tmo
);

  rxc_state_e       state_r, state_nxt;
  logic             rx_en_r;
  logic             ovr_r, irq_wm_r, irq_tmo_r;
  logic [15:0]      tmo_r, tmo_nxt;
  logic [RXQ_W-1:0] head;
  logic [AW:0]      count_next;
  logic             q_full, q_empty, push_ok, pop_ok;
  logic             ovr_set;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (RXQ_W)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (rx_valid),
    .pop        (rd_pop),
    .flush      (flush),
    .wdata      (rxq_pack(rx_berr, rx_ferr, rx_perr, rx_bits)),
    .rdata      (head),
    .count      (count),
    .count_next (count_next),
    .full       (q_full),
    .empty      (q_empty),
    .push_ok    (push_ok),
    .pop_ok     (pop_ok)
  );

  assign rd_valid = ~q_empty;
  assign rd_data  = head[7:0];
  assign rd_err   = {head[8+ERR_BRK], head[8+ERR_FRM], head[8+ERR_PAR]};
  assign rx_en    = rx_en_r;
  assign ovr      = ovr_r;
  assign irq_wm   = irq_wm_r;
  assign irq_tmo  = irq_tmo_r;

  // Enable sequencing: a disable waits for the engine to go idle so no frame is cut.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      UART_RXC_OFF: begin
        if (cfg_en) state_nxt = UART_RXC_RUN;
        else        state_nxt = UART_RXC_OFF;
      end
      UART_RXC_RUN: begin
        if (cfg_en)       state_nxt = UART_RXC_RUN;
        else if (rx_idle) state_nxt = UART_RXC_OFF;
        else              state_nxt = UART_RXC_STOP;
      end
      UART_RXC_STOP: begin
        if (cfg_en)       state_nxt = UART_RXC_RUN;
        else if (rx_idle) state_nxt = UART_RXC_OFF;
        else              state_nxt = UART_RXC_STOP;
      end
      default: state_nxt = UART_RXC_OFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= UART_RXC_OFF;
      rx_en_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      rx_en_r <= (state_nxt == UART_RXC_RUN);
    end
  end

  // A push is lost only when the queue is full, nothing pops and no flush is pending.
  assign ovr_set = rx_valid & ~flush & q_full & ~pop_ok;

  // Timeout counter: runs while data waits and the line is idle, saturating at cfg_tmo.
  always_comb begin
    tmo_nxt = tmo_r;
    if (flush || push_ok || pop_ok || q_empty) begin
      tmo_nxt = 16'd0;
    end else if (rx_idle && (cfg_tmo != 16'd0)) begin
      tmo_nxt = (tmo_r >= cfg_tmo) ? cfg_tmo : (tmo_r + 16'd1);
    end else begin
      tmo_nxt = tmo_r;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovr_r     <= 1'b0;
      irq_wm_r  <= 1'b0;
      irq_tmo_r <= 1'b0;
      tmo_r     <= 16'd0;
    end else begin
      if (ovr_set)      ovr_r <= 1'b1;
      else if (clr_ovr) ovr_r <= 1'b0;
      else              ovr_r <= ovr_r;
      irq_wm_r  <= (count_next > cfg_wm);
      tmo_r     <= tmo_nxt;
      irq_tmo_r <= (cfg_tmo != 16'd0) && (tmo_nxt == cfg_tmo);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_en = 1'b0;
  logic [AW:0] cfg_wm = 4'd8;
  logic [15:0] cfg_tmo = 16'd0;
  logic        flush = 1'b0, clr_ovr = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_bits = 8'h00;
  logic        rx_perr = 1'b0, rx_ferr = 1'b0, rx_berr = 1'b0;
  logic        rx_idle = 1'b1;
  logic        rd_pop = 1'b0;
  logic        rx_en, rd_valid, ovr, irq_wm, irq_tmo;
  logic [7:0]  rd_data;
  logic [2:0]  rd_err;
  logic [AW:0] count;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [10:0] mq[$];
  int          m_state;   // 0 = off, 1 = running, 2 = stopping
  bit          m_ovr, m_wm, m_tmo_irq;
  int          m_t;

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .cfg_en(cfg_en), .cfg_wm(cfg_wm),
    .cfg_tmo(cfg_tmo), .flush(flush), .clr_ovr(clr_ovr), .rx_en(rx_en),
    .rx_valid(rx_valid), .rx_bits(rx_bits), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_berr(rx_berr), .rx_idle(rx_idle), .rd_pop(rd_pop), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .count(count), .ovr(ovr),
    .irq_wm(irq_wm), .irq_tmo(irq_tmo)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_ovr = 0; m_wm = 0; m_tmo_irq = 0; m_t = 0;
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_edge();
    int  sz;
    bit  pop_ok, drop, push_ok;
    sz      = mq.size();
    pop_ok  = rd_pop && sz != 0 && !flush;
    drop    = rx_valid && !flush && sz == DEPTH && !pop_ok;
    push_ok = rx_valid && !flush && !drop;
    case (m_state)
      0: m_state = cfg_en ? 1 : 0;
      1: m_state = cfg_en ? 1 : (rx_idle ? 0 : 2);
      default: m_state = cfg_en ? 1 : (rx_idle ? 0 : 2);
    endcase
    if (flush) mq.delete();
    else begin
      if (pop_ok)  void'(mq.pop_front());
      if (push_ok) mq.push_back({rx_berr, rx_ferr, rx_perr, rx_bits});
    end
    if (drop) m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
    if (flush || pop_ok || push_ok || sz == 0) m_t = 0;
    else if (rx_idle && cfg_tmo != 0) m_t = (m_t + 1 > int'(cfg_tmo)) ? int'(cfg_tmo) : m_t + 1;
    m_tmo_irq = (cfg_tmo != 0) && (m_t == int'(cfg_tmo));
    m_wm = mq.size() > int'(cfg_wm);
  endtask

  task automatic compare_all();
    check_val("rx_en", rx_en, m_state == 1);
    check_val("rd_valid", rd_valid, mq.size() != 0);
    check_val("count", count, mq.size());
    check_val("ovr", ovr, m_ovr);
    check_val("irq_wm", irq_wm, m_wm);
    check_val("irq_tmo", irq_tmo, m_tmo_irq);
    if (mq.size() != 0) begin
      check_val("rd_data", rd_data, mq[0][7:0]);
      check_val("rd_err", rd_err, mq[0][10:8]);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic push_char(input logic [7:0] b, input logic [2:0] e);
    rx_valid = 1'b1; rx_bits = b; {rx_berr, rx_ferr, rx_perr} = e;
    cyc();
    rx_valid = 1'b0; {rx_berr, rx_ferr, rx_perr} = 3'b000;
  endtask

  task automatic pop_one();
    rd_pop = 1'b1; cyc(); rd_pop = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; cyc(); flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rx_en"}, rx_en, 1'b0);
    check_val({tag, "_rd_valid"}, rd_valid, 1'b0);
    check_val({tag, "_rd_data"}, rd_data, 8'h00);
    check_val({tag, "_rd_err"}, rd_err, 3'b000);
    check_val({tag, "_count"}, count, 4'd0);
    check_val({tag, "_ovr"}, ovr, 1'b0);
    check_val({tag, "_irq_wm"}, irq_wm, 1'b0);
    check_val({tag, "_irq_tmo"}, irq_tmo, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    #1;

    // enable and single character
    cfg_en = 1'b1; cyc();
    check_val("en_rx_en", rx_en, 1'b1);
    push_char(8'hA5, 3'b000);
    check_val("a5_data", rd_data, 8'hA5);
    check_val("a5_err", rd_err, 3'b000);
    check_val("a5_count", count, 4'd1);
    pop_one();
    check_val("a5_pop_count", count, 4'd0);

    // watermark and framing flag
    cfg_wm = 4'd2;
    push_char(8'h01, 3'b000);
    push_char(8'h02, 3'b010);
    check_val("wm_before", irq_wm, 1'b0);
    push_char(8'h03, 3'b000);
    check_val("wm_set", irq_wm, 1'b1);
    pop_one();
    check_val("wm_clr", irq_wm, 1'b0);
    check_val("ferr_head_data", rd_data, 8'h02);
    check_val("ferr_head_err", rd_err, 3'b010);
    pop_one(); pop_one();
    pop_one();  // pop on empty ignored
    check_val("empty_pop_count", count, 4'd0);

    // overrun
    cfg_wm = 4'd8;
    for (int i = 0; i < 9; i++) push_char(8'h10 + 8'(i), 3'b000);
    check_val("ovr_count", count, 4'd8);
    check_val("ovr_set", ovr, 1'b1);
    check_val("ovr_head", rd_data, 8'h10);
    rd_pop = 1'b1; push_char(8'h77, 3'b100); rd_pop = 1'b0;
    check_val("full_pp_count", count, 4'd8);
    check_val("full_pp_ovr", ovr, 1'b1);
    check_val("full_pp_head", rd_data, 8'h11);
    clr_ovr = 1'b1; cyc(); clr_ovr = 1'b0;
    check_val("ovr_clr", ovr, 1'b0);
    do_flush();

    // stopping behaviour
    rx_idle = 1'b0; cfg_en = 1'b0; cyc();
    check_val("stop_rx_en", rx_en, 1'b0);
    push_char(8'h5A, 3'b001);
    check_val("late_data", rd_data, 8'h5A);
    check_val("late_err", rd_err, 3'b001);
    cfg_en = 1'b1; cyc();
    check_val("stop_to_run", rx_en, 1'b1);
    cfg_en = 1'b0; cyc();
    rx_idle = 1'b1; cyc();
    check_val("stop_to_off", rx_en, 1'b0);
    do_flush();

    // character timeout
    cfg_tmo = 16'd16;
    push_char(8'h33, 3'b000);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      check_val("tmo_window", irq_tmo, (i == 16) ? 1'b1 : 1'b0);
    end
    pop_one();
    check_val("tmo_pop_clr", irq_tmo, 1'b0);
    cfg_tmo = 16'd0;
    push_char(8'h34, 3'b000);
    for (int i = 0; i < 20; i++) cyc();
    check_val("tmo_disabled", irq_tmo, 1'b0);
    do_flush();

    // flush against a coincident push
    for (int i = 0; i < 5; i++) push_char(8'h40 + 8'(i), 3'b000);
    flush = 1'b1; push_char(8'h99, 3'b000); flush = 1'b0;
    check_val("flush_count", count, 4'd0);
    check_val("flush_valid", rd_valid, 1'b0);
    check_val("flush_ovr", ovr, 1'b0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        cfg_tmo = 16'($urandom_range(0, 6));
        cfg_wm  = 4'($urandom_range(0, 9));
      end
      rx_valid = ($urandom_range(0, 99) < 40);
      rx_bits  = 8'($urandom);
      {rx_berr, rx_ferr, rx_perr} = 3'($urandom);
      rd_pop   = ($urandom_range(0, 99) < 30);
      rx_idle  = ($urandom_range(0, 99) < 70);
      flush    = ($urandom_range(0, 99) < 2);
      clr_ovr  = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 5) cfg_en = ~cfg_en;
      cyc();
      if (n == 1500) begin
        #3 reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
      end
    end
    rx_valid = 1'b0; rd_pop = 1'b0; flush = 1'b0; clr_ovr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
